// File: rtl/divu_8bit.sv
// Sequential unsigned restoring divider.
//
// Divides a DW-bit dividend by a VW-bit divisor and produces one quotient bit per clock.
// It is the inverse of the 4-bit shift-add multiplier: dividing the 8-bit product by one
// factor recovers the other. The results feed the BCD converters and the seven-segment path.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (0 = reset)
//   start      operation request, sampled only while idle
//   dividend   DW-bit dividend, captured on an accepted start
//   divisor    VW-bit divisor, captured on an accepted start
//   busy       high while a division is in progress
//   done       one-cycle pulse; quotient/remainder/dz are valid in the same cycle
//   dz         divide-by-zero flag of the last operation
//   quotient   DW-bit quotient of the last completed operation
//   remainder  VW-bit remainder of the last completed operation
//
// Timing: start accepted at edge k -> DW CALC cycles -> FIN -> done high after edge k+DW+1.
// A zero divisor skips CALC, so done is high after edge k+1.
// quotient, remainder and dz only change in FIN and hold until the next FIN. dz is also
// cleared on the next accepted start. All outputs come straight from flops.

module divu_8bit #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  // Wide enough to hold the value DW itself.
  localparam int unsigned CntW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFin
  } state_e;

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // The partial remainder carries one guard bit so the trial value never overflows.
  logic [VW:0]   r_q, r_d;
  // Dividend bits shift out of the MSB while quotient bits shift into the LSB.
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] dvs_q, dvs_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;

  // Trial remainder: previous remainder shifted left with the next dividend bit appended.
  logic [VW:0] trial;
  logic [VW:0] trial_diff;
  logic        trial_ge;

  always_comb begin
    trial      = {r_q[VW-1:0], q_q[DW-1]};
    trial_diff = trial - {1'b0, dvs_q};
    trial_ge   = (trial >= {1'b0, dvs_q});
  end

  // Since r < divisor after every step, the guard bit of r_q is always zero after the
  // subtract. It is kept for clarity of the datapath width and is deliberately left unread.
  logic unused_r_msb;
  assign unused_r_msb = r_q[VW];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvs_d  = divisor;
          q_d    = dividend;
          r_d    = '0;
          cnt_d  = CntW'(DW);
          busy_d = 1'b1;
          dz_d   = 1'b0;
          // A zero divisor needs no iterations; FIN substitutes the fixed results.
          state_d = (divisor == '0) ? StFin : StCalc;
        end
      end

      StCalc: begin
        r_d   = trial_ge ? trial_diff : trial;
        q_d   = {q_q[DW-2:0], trial_ge};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFin;
        end
      end

      StFin: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
        if (dvs_q == '0) begin
          quot_d = '1;
          rem_d  = '0;
          dz_d   = 1'b1;
        end else begin
          quot_d = q_q;
          rem_d  = r_q[VW-1:0];
          dz_d   = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dz        = dz_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_divu_8bit.sv
// Bench for divu_8bit: directed vectors with literal expectations, a cycle-level
// behavioural model compared against the outputs on every falling edge, and a full
// operand sweep with start held high.

module tb_divu_8bit;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic          dz;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int n_chk  = 0;
  int n_fail = 0;
  int done_count = 0;
  bit chk_en = 1'b0;

  divu_8bit #(
    .DW(DW),
    .VW(VW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .dz       (dz),
    .quotient (quotient),
    .remainder(remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation occupies DW+1 clocks (1 for a zero divisor) after it
  // is accepted; results come from plain arithmetic and appear together with done.
  int            m_left;
  logic          m_busy, m_done, m_dz, p_dz;
  logic [DW-1:0] m_q, p_q;
  logic [VW-1:0] m_r, p_r;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      p_q    <= '0;
      p_r    <= '0;
      p_dz   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_busy <= 1'b1;
          m_dz   <= 1'b0;
          if (divisor == 0) begin
            p_q    <= '1;
            p_r    <= '0;
            p_dz   <= 1'b1;
            m_left <= 1;
          end else begin
            p_q    <= dividend / {4'b0, divisor};
            p_r    <= VW'(dividend % {4'b0, divisor});
            p_dz   <= 1'b0;
            m_left <= DW + 1;
          end
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
          m_dz   <= p_dz;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model busy", busy, m_busy);
      chk("model done", done, m_done);
      chk("model dz", dz, m_dz);
      chk("model quotient", quotient, m_q);
      chk("model remainder", remainder, m_r);
      if (done) done_count <= done_count + 1;
    end
  end

  // One directed operation. poke > 0 pulses start with other operands that many
  // cycles after acceptance; it must be ignored.
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int eq,
                        input int er, input int edz, input int elat, input int poke);
    int lat;
    int bcnt;
    int d0;
    bit seen;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    d0 = done_count;
    @(negedge clk);
    start = 1'b0;
    bcnt  = int'(busy);
    lat   = 0;
    seen  = 1'b0;
    while (!seen && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == poke) begin
        start    = 1'b1;
        dividend = 8'd99;
        divisor  = 4'd9;
      end else begin
        start = 1'b0;
      end
      bcnt += int'(busy);
      if (done) seen = 1'b1;
    end
    chk($sformatf("%0d/%0d latency", a, b), seen ? lat : -1, elat);
    chk($sformatf("%0d/%0d busy cycles", a, b), bcnt, elat);
    chk($sformatf("%0d/%0d quotient", a, b), quotient, eq);
    chk($sformatf("%0d/%0d remainder", a, b), remainder, er);
    chk($sformatf("%0d/%0d dz", a, b), dz, edz);
    chk($sformatf("%0d/%0d model quotient", a, b), m_q, eq);
    chk($sformatf("%0d/%0d model remainder", a, b), m_r, er);
    repeat (3) @(negedge clk);
    chk($sformatf("%0d/%0d done pulses", a, b), done_count - d0, 1);
  endtask

  initial begin
    int d0;
    int idx;
    bit seen;
    logic [DW-1:0] cur_a;
    logic [VW-1:0] cur_b;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dz", dz, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    reset = 1'b1;

    run_op(8'd200, 4'd7, 28, 4, 0, 9, 0);
    run_op(8'd255, 4'd1, 255, 0, 0, 9, 0);
    run_op(8'd255, 4'd15, 17, 0, 0, 9, 0);
    run_op(8'd3, 4'd9, 0, 3, 0, 9, 0);
    run_op(8'd0, 4'd5, 0, 0, 0, 9, 0);
    run_op(8'd100, 4'd0, 255, 0, 1, 1, 0);
    run_op(8'd100, 4'd10, 10, 0, 0, 9, 0);
    run_op(8'd150, 4'd4, 37, 2, 0, 9, 3);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre-reset busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset done", done, 0);
    chk("async reset quotient", quotient, 0);
    chk("async reset remainder", remainder, 0);
    d0 = done_count;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("aborted op done pulses", done_count - d0, 0);
    run_op(8'd20, 4'd3, 6, 2, 0, 9, 0);

    // Sweep every operand pair in a scrambled order with start held high.
    @(negedge clk);
    idx      = 0;
    cur_a    = DW'(idx >> 4);
    cur_b    = VW'(idx);
    dividend = cur_a;
    divisor  = cur_b;
    start    = 1'b1;
    for (int p = 0; p < 4096; p++) begin
      seen = 1'b0;
      for (int w = 0; w < 30 && !seen; w++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      chk("sweep done seen", seen, 1);
      if (cur_b == 0) begin
        chk($sformatf("sweep %0d/0 dz", cur_a), dz, 1);
        chk($sformatf("sweep %0d/0 quotient", cur_a), quotient, 255);
        chk($sformatf("sweep %0d/0 remainder", cur_a), remainder, 0);
      end else begin
        chk($sformatf("sweep %0d/%0d q*d+r", cur_a, cur_b),
            int'(quotient) * int'(cur_b) + int'(remainder), cur_a);
        chk($sformatf("sweep %0d/%0d r<d", cur_a, cur_b), remainder < cur_b, 1);
        chk($sformatf("sweep %0d/%0d dz", cur_a, cur_b), dz, 0);
      end
      if (p < 4095) begin
        idx      = ((p + 1) * 1237) % 4096;
        cur_a    = DW'(idx >> 4);
        cur_b    = VW'(idx);
        dividend = cur_a;
        divisor  = cur_b;
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
